rom_fetch_unit: RTL and testbench

ROM_FETCH_UNIT -- requirements
Module: rom_fetch_unit

---
 rtl/rom_fetch_unit.sv | 134 +++++++++++++
 tb/tb_rom_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
// Instruction fetch from a 64-bit combinational ROM.
// Buffers {pc, instr} in a small FIFO.
module rom_fetch_unit #(
  parameter logic [35:0] RESET_PC   = 36'h1_0000_0000,
  parameter logic [35:0] ROM_BASE   = 36'h1_0000_0000,
  parameter logic [35:0] ROM_BYTES  = 36'h170,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [35:0] rom_addr,
  input  logic [63:0] rom_data,
  input  logic        redirect_valid,
  input  logic [35:0] redirect_pc,
  input  logic        halt_req,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [35:0] instr_pc,
  output logic        fault,
  output logic [4:0]  fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);
  localparam logic [36:0] ROM_LO = {1'b0, ROM_BASE};
  localparam logic [36:0] ROM_HI =
    {1'b0, ROM_BASE} + {1'b0, ROM_BYTES};

  typedef enum logic [1:0] {
    FETCH, FULL, HALTED, FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [35:0]   pc_q, pc_d;
  logic [4:0]    count_q, count_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [67:0]   mem_q [FIFO_DEPTH];

  logic          push, pop, in_range;
  logic [31:0]   fetch_word;
  logic [67:0]   head;

  assign rom_addr   = pc_q;
  assign fetch_word = pc_q[2] ? rom_data[63:32]
                              : rom_data[31:0];
  assign in_range   = ({1'b0, pc_q} >= ROM_LO) &&
                      ({1'b0, pc_q} <  ROM_HI);

  assign head        = mem_q[rd_q];
  assign instr_valid = (count_q != 5'd0);
  assign instr_data  = instr_valid ? head[31:0]  : '0;
  assign instr_pc    = instr_valid ? head[67:32] : '0;
  assign fault       = (state_q == FAULT);
  assign fifo_count  = count_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = instr_valid & instr_ready;
    if (redirect_valid) begin
      pop     = 1'b0;
      pc_d    = {redirect_pc[35:2], 2'b00};
      state_d = halt_req ? HALTED : FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (halt_req) begin
            state_d = HALTED;
          end else if (!in_range) begin
            state_d = FAULT;
          end else if (count_q < DEPTH) begin
            push = 1'b1;
            pc_d = pc_q + 36'd4;
            if (count_q + 5'd1 == DEPTH && !pop)
              state_d = FULL;
          end else if (!pop) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (halt_req)  state_d = HALTED;
          else if (pop)  state_d = FETCH;
        end
        HALTED: begin
          if (!halt_req) state_d = FETCH;
        end
        FAULT: state_d = FAULT;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (redirect_valid) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + {4'd0, push}
                        - {4'd0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Payload needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= {pc_q, fetch_word};
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit.
// Scenario tasks with hand-computed vectors.
module tb_rom_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [35:0] rom_addr;
  logic [63:0] rom_data;
  logic        redirect_valid;
  logic [35:0] redirect_pc;
  logic        halt_req;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [35:0] instr_pc;
  logic        fault;
  logic [4:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [35:0] B = 36'h1_0000_0000;

  rom_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fault          (fault),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(
    input logic [35:0] a
  );
    logic [35:0] off;
    off = a - B;
    if (a < B || off >= 36'h170)
      return 32'hDEAD_BEEF;
    case (off)
      36'h000: return 32'h0400_00FF;
      36'h004: return 32'h1400_004F;
      36'h010: return 32'h0038_0180;
      36'h168: return 32'h4E20_6279;
      36'h16C: return 32'h2020_2020;
      default: return {8'hA5, off[23:0]};
    endcase
  endfunction

  assign rom_data = {
    rom_word({rom_addr[35:3], 3'b100}),
    rom_word({rom_addr[35:3], 3'b000})
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    instr_ready    = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = B + 36'h40;
    halt_req       = 1'b1;
    instr_ready    = 1'b1;
    tick();
    tick();
    n_tests++;
    if (fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_count got %0d exp 0", fifo_count);
    end
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b exp 0", instr_valid);
    end
    n_tests++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fault got %b exp 0", fault);
    end
    n_tests++;
    if (instr_data !== 32'h0 || instr_pc !== 36'h0) begin
      n_fail++;
      $display("FAIL rst_head got %h/%h exp 0/0",
               instr_pc, instr_data);
    end
    n_tests++;
    if (rom_addr !== B) begin
      n_fail++;
      $display("FAIL rst_addr got %h exp %h", rom_addr, B);
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_d [6];
    exp_d = '{32'h0400_00FF, 32'h1400_004F,
              32'hA500_0008, 32'hA500_000C,
              32'h0038_0180, 32'hA500_0014};
    do_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b1 ||
          instr_pc !== B + 36'(4 * i) ||
          instr_data !== exp_d[i] ||
          fifo_count !== 5'd1) begin
        n_fail++;
        $display("FAIL stream%0d got v%b %h/%h c%0d exp v1 %h/%h c1",
                 i, instr_valid, instr_pc, instr_data,
                 fifo_count, B + 36'(4 * i), exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (fifo_count !== 5'd4) begin
      n_fail++;
      $display("FAIL bp_count got %0d exp 4", fifo_count);
    end
    n_tests++;
    if (rom_addr !== B + 36'h10) begin
      n_fail++;
      $display("FAIL bp_addr got %h exp %h",
               rom_addr, B + 36'h10);
    end
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== B ||
        instr_data !== 32'h0400_00FF) begin
      n_fail++;
      $display("FAIL bp_head got v%b %h/%h exp v1 %h/040000ff",
               instr_valid, instr_pc, instr_data, B);
    end
    instr_ready = 1'b1;
    tick();
    n_tests++;
    if (fifo_count !== 5'd3 || instr_pc !== B + 36'h4) begin
      n_fail++;
      $display("FAIL full_pop got c%0d %h exp c3 %h",
               fifo_count, instr_pc, B + 36'h4);
    end
    instr_ready = 1'b0;
    tick();
    n_tests++;
    if (fifo_count !== 5'd4 || rom_addr !== B + 36'h14) begin
      n_fail++;
      $display("FAIL refill got c%0d %h exp c4 %h",
               fifo_count, rom_addr, B + 36'h14);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = B + 36'h13;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (fifo_count !== 5'd0 || instr_valid !== 1'b0 ||
        rom_addr !== B + 36'h10) begin
      n_fail++;
      $display("FAIL redir_flush got c%0d v%b %h exp c0 v0 %h",
               fifo_count, instr_valid, rom_addr, B + 36'h10);
    end
    tick();
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== B + 36'h10 ||
        instr_data !== 32'h0038_0180) begin
      n_fail++;
      $display("FAIL redir_head got v%b %h/%h exp v1 %h/00380180",
               instr_valid, instr_pc, instr_data, B + 36'h10);
    end
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1;
    redirect_pc    = B + 36'h168;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_tests++;
    if (instr_pc !== B + 36'h168 ||
        instr_data !== 32'h4E20_6279) begin
      n_fail++;
      $display("FAIL flt_w0 got %h/%h exp %h/4e206279",
               instr_pc, instr_data, B + 36'h168);
    end
    tick();
    n_tests++;
    if (instr_pc !== B + 36'h16C ||
        instr_data !== 32'h2020_2020 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL flt_w1 got %h/%h f%b exp %h/20202020 f0",
               instr_pc, instr_data, fault, B + 36'h16C);
    end
    tick();
    n_tests++;
    if (fault !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flt_enter got f%b v%b exp f1 v0",
               fault, instr_valid);
    end
    tick();
    n_tests++;
    if (fault !== 1'b1 || fifo_count !== 5'd0 ||
        rom_addr !== B + 36'h170) begin
      n_fail++;
      $display("FAIL flt_hold got f%b c%0d %h exp f1 c0 %h",
               fault, fifo_count, rom_addr, B + 36'h170);
    end
    redirect_valid = 1'b1;
    redirect_pc    = B;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL flt_clear got %b exp 0", fault);
    end
    tick();
    n_tests++;
    if (instr_pc !== B || instr_data !== 32'h0400_00FF) begin
      n_fail++;
      $display("FAIL flt_resume got %h/%h exp %h/040000ff",
               instr_pc, instr_data, B);
    end
  endtask

  task automatic test_halt();
    do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    halt_req    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (rom_addr !== B + 36'h8) begin
        n_fail++;
        $display("FAIL halt_addr%0d got %h exp %h",
                 i, rom_addr, B + 36'h8);
      end
    end
    n_tests++;
    if (fifo_count !== 5'd0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_drain got c%0d v%b exp c0 v0",
               fifo_count, instr_valid);
    end
    halt_req = 1'b0;
    tick();
    tick();
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== B + 36'h8 ||
        instr_data !== 32'hA500_0008) begin
      n_fail++;
      $display("FAIL halt_resume got v%b %h/%h exp v1 %h/a5000008",
               instr_valid, instr_pc, instr_data, B + 36'h8);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    n_tests++;
    if (fifo_count !== 5'd3) begin
      n_fail++;
      $display("FAIL mid_pre got %0d exp 3", fifo_count);
    end
    rst_n          = 1'b0;
    halt_req       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = B + 36'h100;
    tick();
    n_tests++;
    if (fifo_count !== 5'd0 || instr_valid !== 1'b0 ||
        rom_addr !== B) begin
      n_fail++;
      $display("FAIL mid_rst got c%0d v%b %h exp c0 v0 %h",
               fifo_count, instr_valid, rom_addr, B);
    end
    rst_n          = 1'b1;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    instr_ready    = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
